// File: rtl/sort_frame_ctrl.sv
// rtl/sort_frame_ctrl.sv - framing and handshake controller around the sorting stack
module sort_frame_ctrl #(
   parameter int HBIT   = 15,
   parameter int R_SZ   = 256,
   parameter int CNT_W  = 9,
   parameter int ASCEND = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic [HBIT:0]   in_data,
   input  logic            in_last,
   output logic            in_ready,
   output logic            out_valid,
   output logic [HBIT:0]   out_data,
   output logic            out_last,
   input  logic            out_ready,
   output logic            s_hold,
   output logic            s_is_input,
   output logic [HBIT:0]   s_data_in,
   input  logic [HBIT:0]   s_data_out,
   output logic            overflow,
   output logic [CNT_W-1:0] frame_len
);

   typedef enum logic [1:0] {FLUSH, LOAD, DRAIN} state_t;

   localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(R_SZ - 1);
   localparam logic [CNT_W-1:0] CAP        = CNT_W'(R_SZ);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] flush_cnt, flush_cnt_nx;
   logic             overflow_q, overflow_nx;

   // Ascending order stores -1-x, which is the bitwise complement.
   assign s_data_in = (ASCEND != 0) ? ~in_data : in_data;
   assign out_data  = (ASCEND != 0) ? ~s_data_out : s_data_out;
   assign overflow  = overflow_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FLUSH;
         cnt        <= '0;
         flush_cnt  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         flush_cnt  <= flush_cnt_nx;
         overflow_q <= overflow_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      flush_cnt_nx = flush_cnt;
      overflow_nx  = overflow_q;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_last     = 1'b0;
      s_hold       = 1'b0;
      s_is_input   = 1'b0;
      frame_len    = '0;
      if (!reset) begin
         unique case (state)
            FLUSH: begin
               // Popping with hold low shifts zeros in; R_SZ pops clear the stack.
               flush_cnt_nx = flush_cnt + ONE;
               if (flush_cnt == FLUSH_LAST) begin
                  state_nx = LOAD;
               end
            end
            LOAD: begin
               s_is_input = 1'b1;
               in_ready   = 1'b1;
               s_hold     = ~in_valid;
               frame_len  = cnt;
               if (in_valid) begin
                  cnt_nx = cnt + ONE;
                  if (in_last) begin
                     state_nx = DRAIN;
                  end else if ((cnt + ONE) == CAP) begin
                     state_nx    = DRAIN;
                     overflow_nx = 1'b1;
                  end
               end
            end
            DRAIN: begin
               out_valid = 1'b1;
               s_hold    = ~out_ready;
               out_last  = (cnt == ONE);
               frame_len = cnt;
               if (out_ready) begin
                  cnt_nx = cnt - ONE;
                  // Every loaded entry has been popped, so the stack is zero again.
                  if (cnt == ONE) begin
                     state_nx = LOAD;
                     cnt_nx   = '0;
                  end
               end
            end
            default: begin
               state_nx = FLUSH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// tb/tb_sort_frame_ctrl.sv - randomized self-checking bench for sort_frame_ctrl
module tb_sort_frame_ctrl;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
      logic [15:0] rem;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset     [2];
   logic        in_valid  [2];
   logic        in_last   [2];
   logic        out_ready [2];
   logic [15:0] in_data   [2];
   logic        in_ready  [2];
   logic        out_valid [2];
   logic        out_last  [2];
   logic        s_hold    [2];
   logic        s_is_input[2];
   logic        overflow  [2];
   logic [15:0] out_data  [2];
   logic [15:0] s_data_in [2];
   logic [15:0] s_data_out[2];
   logic [2:0]  fl0;
   logic [3:0]  fl1;

   sort_frame_ctrl #(.HBIT(15), .R_SZ(4), .CNT_W(3), .ASCEND(0)) u_dut0 (
      .clk(clk), .reset(reset[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_last(in_last[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
      .out_data(out_data[0]), .out_last(out_last[0]), .out_ready(out_ready[0]),
      .s_hold(s_hold[0]), .s_is_input(s_is_input[0]), .s_data_in(s_data_in[0]),
      .s_data_out(s_data_out[0]), .overflow(overflow[0]), .frame_len(fl0)
   );

   sort_frame_ctrl #(.HBIT(15), .R_SZ(8), .CNT_W(4), .ASCEND(1)) u_dut1 (
      .clk(clk), .reset(reset[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_last(in_last[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
      .out_data(out_data[1]), .out_last(out_last[1]), .out_ready(out_ready[1]),
      .s_hold(s_hold[1]), .s_is_input(s_is_input[1]), .s_data_in(s_data_in[1]),
      .s_data_out(s_data_out[1]), .overflow(overflow[1]), .frame_len(fl1)
   );

   function automatic int rsz(input int k);
      return (k == 0) ? 4 : 8;
   endfunction

   function automatic logic [31:0] flen(input int k);
      return (k == 0) ? 32'(fl0) : 32'(fl1);
   endfunction

   // Stack environment: descending register stack, top at index 0, power-up garbage.
   logic [15:0] mem [2][8];
   logic        seeded = 1'b0;
   assign s_data_out[0] = mem[0][0];
   assign s_data_out[1] = mem[1][0];

   function automatic int ins_pos(input int k, input logic [15:0] x);
      for (int i = 0; i < rsz(k); i++) if (mem[k][i] < x) return i;
      return rsz(k);
   endfunction

   always @(posedge clk) begin
      if (!seeded) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) mem[k][i] <= 16'($urandom);
         seeded <= 1'b1;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!s_hold[k]) begin
               for (int i = 0; i < rsz(k); i++) begin
                  if (s_is_input[k]) begin
                     if (i == ins_pos(k, s_data_in[k])) mem[k][i] <= s_data_in[k];
                     else if (i > ins_pos(k, s_data_in[k])) mem[k][i] <= mem[k][i-1];
                  end else if (i == rsz(k) - 1) begin
                     mem[k][i] <= 16'h0;
                  end else begin
                     mem[k][i] <= mem[k][i+1];
                  end
               end
            end
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   beat_t exp_q[$];
   int    exp_ov[2];
   int    pop_cnt = 0;
   int    base = 0;
   int    sel = 0;

   always @(negedge clk) begin
      if (!reset[sel] && out_valid[sel]) begin
         if (pop_cnt - base < exp_q.size()) begin
            chk("out_data", 32'(out_data[sel]), 32'(exp_q[pop_cnt-base].data));
            chk("out_last", 32'(out_last[sel]), 32'(exp_q[pop_cnt-base].last));
            chk("frame_len", flen(sel), 32'(exp_q[pop_cnt-base].rem));
         end else begin
            chk("extra_beat", pop_cnt - base, exp_q.size());
         end
         if (out_ready[sel]) pop_cnt <= pop_cnt + 1;
      end
   end

   // Reference: split into frames at in_last or capacity, then sort each frame.
   task automatic set_expect(input int k, input logic [15:0] d[$], input logic l[$]);
      logic [15:0] cur[$];
      exp_q.delete();
      for (int i = 0; i < d.size(); i++) begin
         cur.push_back(d[i]);
         if (l[i] || cur.size() == rsz(k)) begin
            if (!l[i]) exp_ov[k] = 1;
            if (k == 1) cur.sort();
            else cur.rsort();
            for (int j = 0; j < cur.size(); j++)
               exp_q.push_back('{cur[j], (j == cur.size() - 1), 16'(cur.size() - j)});
            cur.delete();
         end
      end
      base = pop_cnt;
      sel  = k;
   endtask

   task automatic send_beats(input int k, input logic [15:0] d[$], input logic l[$], input int gap_pct);
      int t;
      for (int i = 0; i < d.size(); i++) begin
         while ($urandom_range(99) < gap_pct) begin
            in_valid[k] = 1'b0;
            @(posedge clk); #1;
         end
         in_valid[k] = 1'b1;
         in_data[k]  = d[i];
         in_last[k]  = l[i];
         t = 0;
         while (!in_ready[k] && t < 300) begin
            @(posedge clk); #1;
            t++;
         end
         chk("accept", 32'(in_ready[k]), 1);
         @(posedge clk); #1;
      end
      in_valid[k] = 1'b0;
      in_last[k]  = 1'b0;
   endtask

   task automatic run(input int k, input logic [15:0] d[$], input logic l[$],
                      input int ready_pct, input int gap_pct, input logic pat[$]);
      set_expect(k, d, l);
      fork
         send_beats(k, d, l, gap_pct);
         begin
            int c  = 0;
            int pi = 0;
            while ((pop_cnt - base) < exp_q.size() && c < 3000) begin
               if (pi < pat.size() && out_valid[k]) begin
                  out_ready[k] = pat[pi];
                  pi++;
               end else begin
                  out_ready[k] = ($urandom_range(99) < ready_pct);
               end
               @(posedge clk); #1;
               c++;
            end
            out_ready[k] = 1'b0;
         end
      join
      chk("all_beats", pop_cnt - base, exp_q.size());
      chk("overflow", 32'(overflow[k]), exp_ov[k]);
   endtask

   task automatic flush_wait(input int k);
      int c = 0;
      chk("flush_ready_low", 32'(in_ready[k]), 0);
      while (!in_ready[k] && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      chk("flush_cycles", c, rsz(k));
   endtask

   function automatic logic [15:0] rnd_val();
      case ($urandom_range(3))
         0:       return 16'h0000;
         1:       return 16'hffff;
         2:       return 16'($urandom_range(7));
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation bound reached");
      $fatal(1);
   end

   initial begin
      logic [15:0] d[$];
      logic        l[$];
      logic        none[$];
      logic        pat[$];
      int          first[2];
      int          len;

      for (int k = 0; k < 2; k++) begin
         reset[k] = 1'b1; in_valid[k] = 1'b0; in_last[k] = 1'b0;
         in_data[k] = '0; out_ready[k] = 1'b0; exp_ov[k] = 0;
      end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", 32'(in_ready[k]), 0);
         chk("rst_out_valid", 32'(out_valid[k]), 0);
         chk("rst_out_last", 32'(out_last[k]), 0);
         chk("rst_s_hold", 32'(s_hold[k]), 0);
         chk("rst_s_is_input", 32'(s_is_input[k]), 0);
         chk("rst_overflow", 32'(overflow[k]), 0);
         chk("rst_frame_len", flen(k), 0);
      end
      reset[0] = 1'b0;
      reset[1] = 1'b0;
      first[0] = -1;
      first[1] = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) if (in_ready[k] && first[k] < 0) first[k] = c;
      end
      chk("flush_len0", first[0], 4);
      chk("flush_len1", first[1], 8);

      d = '{16'd5, 16'd1, 16'd9, 16'd3};
      l = '{1'b0, 1'b0, 1'b0, 1'b1};
      set_expect(0, d, l);
      out_ready[0] = 1'b1;
      send_beats(0, d, l, 0);
      chk("lat_out_valid", 32'(out_valid[0]), 1);
      chk("lat_out_data", 32'(out_data[0]), 9);
      chk("lat_frame_len", flen(0), 4);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("full_rate", pop_cnt - base, 4);
      chk("turnaround", 32'(in_ready[0]), 1);
      out_ready[0] = 1'b0;

      d = '{16'd7, 16'd0, 16'hffff, 16'd2, 16'd4, 16'd4};
      l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      run(1, d, l, 100, 0, none);

      d = '{16'd3, 16'd8, 16'd6};
      l = '{1'b0, 1'b0, 1'b1};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      run(0, d, l, 0, 0, pat);
      run(0, d, l, 50, 50, none);

      d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
      l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      run(0, d, l, 100, 0, none);

      d = '{16'd9, 16'd2, 16'd5};
      l = '{1'b0, 1'b0, 1'b1};
      set_expect(0, d, l);
      send_beats(0, d, l, 0);
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      chk("mid_drain_popped", pop_cnt - base, 1);
      reset[0] = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_out_valid", 32'(out_valid[0]), 0);
      chk("mid_rst_overflow", 32'(overflow[0]), 0);
      chk("mid_rst_frame_len", flen(0), 0);
      reset[0]  = 1'b0;
      exp_ov[0] = 0;
      exp_q.delete();
      flush_wait(0);
      d = '{16'd1, 16'd3};
      l = '{1'b0, 1'b1};
      run(0, d, l, 100, 0, none);

      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 8; r++) begin
            d.delete();
            l.delete();
            for (int f = 0; f < 3; f++) begin
               len = ($urandom_range(4) == 0) ? rsz(k) + int'($urandom_range(1, 3))
                                              : int'($urandom_range(1, rsz(k)));
               for (int i = 0; i < len; i++) begin
                  d.push_back(rnd_val());
                  l.push_back(i == len - 1);
               end
            end
            run(k, d, l, int'($urandom_range(30, 100)), int'($urandom_range(0, 50)), none);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sort_frame_ctrl.md
Name: sort_frame_ctrl

Overview:
- Framing and handshake controller wrapped around the Sorting_Stack storage.
- Upstream side: accepts a frame of numbers on a valid/ready stream terminated by a last flag.
- Downstream side: drives the stack's hold/is_input/data_in, then streams the sorted frame out with valid/ready/last.
- Also performs the flush the stack needs, because the stack has no reset of its own.

Parameters:
- HBIT, 15: MSB index of a number; width is HBIT+1.
- R_SZ, 256: capacity of the attached stack; also the maximum frame length.
- CNT_W, 9: counter width; must satisfy 2^CNT_W > R_SZ.
- ASCEND, 0: 0 = output in decreasing order; 1 = increasing order (data is inverted as -1-x on the way into the stack and again on the way out).

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: upstream beat valid.
- in_data, in, HBIT+1: upstream number.
- in_last, in, 1: marks the final beat of a frame.
- in_ready, out, 1: controller accepts the beat.
- out_valid, out, 1: sorted beat valid.
- out_data, out, HBIT+1: sorted number.
- out_last, out, 1: marks the final sorted beat.
- out_ready, in, 1: downstream accepts the beat.
- s_hold, out, 1: to stack hold.
- s_is_input, out, 1: to stack is_input.
- s_data_in, out, HBIT+1: to stack data_in.
- s_data_out, in, HBIT+1: from stack data_out.
- overflow, out, 1: sticky; set when a frame reached R_SZ beats without in_last.
- frame_len, out, CNT_W: length of the frame currently held or being drained.

Behaviour:
- State machine, three states: FLUSH, LOAD, DRAIN. Registers: state, cnt (CNT_W bits), flush_cnt, overflow.
- reset (sampled at posedge): state=FLUSH, cnt=0, flush_cnt=0, overflow=0. This applies from any state, including mid-LOAD or mid-DRAIN; any partial frame is discarded with no out_last.
- Output values while reset is asserted or in FLUSH: in_ready=0, out_valid=0, out_last=0, frame_len=0, s_is_input=0, s_hold=0.
- FLUSH:
  - Runs exactly R_SZ cycles with s_hold=0 and s_is_input=0, so the stack fills with zeros.
  - flush_cnt increments each cycle; on flush_cnt==R_SZ-1 the next state is LOAD.
- LOAD:
  - s_is_input=1; in_ready=1.
  - s_data_in = in_data, or (-1-in_data) when ASCEND=1.
  - s_hold = ~(in_valid & in_ready): the stack advances only on an accepted beat.
  - On an accepted beat: cnt <= cnt+1.
  - If in_last=1, next state is DRAIN.
  - Else if cnt+1==R_SZ, next state is DRAIN and overflow<=1; any following beats belong to the next frame.
  - With no accepted beat, state and the stack contents are unchanged.
- DRAIN:
  - s_is_input=0; out_valid=1; s_hold = ~out_ready; in_ready=0.
  - out_data = s_data_out, or (-1-s_data_out) when ASCEND=1. This path is combinational from the stack.
  - out_last = (cnt==1).
  - On handshake: cnt <= cnt-1. On the handshake where out_last=1, next state is LOAD with cnt=0; the stack is then all-zero again, so no re-flush is needed.
  - While out_ready=0, out_data and out_last stay stable, because the stack is held.
- frame_len = cnt in LOAD and DRAIN.
- Latency:
  - The last input beat is accepted at edge t; out_valid=1 in the cycle after t, carrying the frame maximum (or minimum when ASCEND=1).
  - Full rate is one output per cycle with out_ready held high.
  - Frame-to-frame turnaround is 0 cycles: in_ready=1 in the cycle after the last output handshake.
- Value 0 (ASCEND=0) or all-ones (ASCEND=1) is a legal datum. Ordering is unaffected because cnt bounds the output.
- Sort is stable, inherited from the stack.
- overflow clears only on reset.

Test Plan:
1. Reset, then hold in_valid=0 -> in_ready stays 0 for exactly R_SZ cycles after reset deasserts, then rises to 1.
2. ASCEND=0: frame 5,1,9,3 (last on 3), out_ready=1 -> out_data 9,5,3,1 on consecutive cycles; out_last only with 1; frame_len=4 in the first DRAIN cycle.
3. ASCEND=1: frame 7,0,65535,2 -> out_data 0,2,7,65535; then a second frame 4,4 -> 4,4 with out_last on the second beat, no gap before in_ready.
4. Backpressure: frame 3,8,6; toggle out_ready 1,0,0,1,1 -> out_data 8, held 6, held 6, 6, 3; no duplication or loss. Also insert in_valid gaps during LOAD -> same result.
5. R_SZ=4, frame 1..6 with no in_last -> first 4 beats drain as 4,3,2,1 with out_last on 1 and overflow=1; beats 5,6 form the next frame.
6. Reset asserted mid-DRAIN of frame 9,2,5 after one output -> out_valid=0 the next cycle, FLUSH for R_SZ cycles; new frame 1,3 -> outputs 3,1 with no residue of the old frame.
